instr_fetch: RTL and testbench

Instruction fetch stage of the MIPS single-cycle CPU. Sits directly upstream of the control decoder.
Holds the PC and fetches one word per instruction from instruction memory over a req/ack handshake. Presents the word (opcode = instr[31:26], funct = instr[5:0]) to decode/execute.
Computes the next PC from the redirect signals that execute returns at instruction completion.

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, decode outputs and execute redirect inputs.
// master = fetch unit; slave = memory/execute environment.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        exec_done;
  logic        branch;
  logic        zero;
  logic [31:0] sign_imm;
  logic        jump;
  logic        jr;
  logic [31:0] rs_val;
  logic        align_err;

  modport master (
    output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, align_err,
    input  imem_ack, imem_rdata, exec_done, branch, zero, sign_imm, jump, jr, rs_val
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, align_err,
    output imem_ack, imem_rdata, exec_done, branch, zero, sign_imm, jump, jr, rs_val
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over req/ack,
// and computes the next PC from execute's redirect inputs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH, ISSUE, EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        align_q, align_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (bus.jr)
      next_pc = {bus.rs_val[31:2], 2'b00};
    else if (bus.jump)
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (bus.branch && bus.zero)
      next_pc = pc_plus4 + (bus.sign_imm << 2);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    align_d = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = EXEC;
      EXEC: begin
        if (bus.exec_done) begin
          pc_d    = next_pc;
          align_d = bus.jr && (bus.rs_val[1:0] != 2'b00);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      align_q <= align_d;
    end
  end

  // Request is gated by rst so it stays low through the reset cycle regardless of prior state.
  assign bus.imem_req    = (state_q == FETCH) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.align_err   = align_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level PC model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_issued = 0;
  int   n_valid_seen = 0;
  logic [31:0] m_pc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.instr_valid) n_valid_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.exec_done  = 1'b0;
    bus.branch     = 1'b0;
    bus.zero       = 1'b0;
    bus.sign_imm   = '0;
    bus.jump       = 1'b0;
    bus.jr         = 1'b0;
    bus.rs_val     = '0;
  endtask

  // Reference next-PC from the architectural redirect rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic br, input logic z, input logic j,
                                           input logic r, input logic [31:0] simm,
                                           input logic [31:0] rs);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (r)            return rs & 32'hFFFF_FFFC;
    else if (j)       return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    else if (br && z) return seq + simm * 4;
    else              return seq;
  endfunction

  // One full instruction: fetch with waits, issue, execute with optional stall, redirect.
  task automatic run_instr(input logic [31:0] rdata, input int waits, input int ex_waits,
                           input logic br, input logic z, input logic j, input logic r,
                           input logic [31:0] simm, input logic [31:0] rs, input bit noise);
    logic [31:0] exp_next;
    check_eq("fetch_req", {31'b0, bus.imem_req}, 32'd1);
    check_eq("fetch_addr", bus.imem_addr, m_pc);
    for (int w = 0; w < waits; w++) begin
      bus.exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      check_eq("wait_req", {31'b0, bus.imem_req}, 32'd1);
      check_eq("wait_addr", bus.imem_addr, m_pc);
      check_eq("wait_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    bus.exec_done  = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    step();
    n_issued++;
    check_eq("issue_valid", {31'b0, bus.instr_valid}, 32'd1);
    check_eq("issue_req", {31'b0, bus.imem_req}, 32'd0);
    check_eq("issue_instr", bus.instr, rdata);
    check_eq("issue_pc", bus.pc, m_pc);
    check_eq("issue_pc4", bus.pc_plus4, m_pc + 32'd4);
    check_eq("issue_align", {31'b0, bus.align_err}, 32'd0);
    bus.imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.imem_rdata = $urandom;
    bus.exec_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    check_eq("exec_valid", {31'b0, bus.instr_valid}, 32'd0);
    for (int w = 0; w < ex_waits; w++) begin
      bus.imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.imem_rdata = $urandom;
      bus.exec_done  = 1'b0;
      step();
      check_eq("exec_hold_pc", bus.pc, m_pc);
      check_eq("exec_hold_instr", bus.instr, rdata);
      check_eq("exec_hold_req", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.imem_ack  = 1'b0;
    bus.exec_done = 1'b1;
    bus.branch    = br;
    bus.zero      = z;
    bus.jump      = j;
    bus.jr        = r;
    bus.sign_imm  = simm;
    bus.rs_val    = rs;
    exp_next = ref_next(m_pc, rdata, br, z, j, r, simm, rs);
    step();
    idle_inputs();
    check_eq("align_err", {31'b0, bus.align_err}, {31'b0, r && (rs[1:0] != 2'b00)});
    check_eq("next_pc", bus.pc, exp_next);
    m_pc = exp_next;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    run_instr(32'h0000_0008, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, '0, tgt, 1'b0);
  endtask

  initial begin
    idle_inputs();
    m_pc = RST_PC;
    rst = 1'b1;
    step();
    step();
    check_eq("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check_eq("rst_align", {31'b0, bus.align_err}, 32'd0);
    check_eq("rst_instr", bus.instr, 32'd0);
    check_eq("rst_pc", bus.pc, RST_PC);
    rst = 1'b0;
    #1;

    // Sequential addi stream with zero-wait memory.
    for (int i = 0; i < 3; i++)
      run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check_eq("seq_pc", bus.pc, 32'h0000_000C);

    // Wait states at 0x10.
    run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_instr(32'h1234_5678, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Branch taken/not taken from 0x20.
    jr_to(32'h0000_0020);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, '0, 1'b0);
    check_eq("branch_taken", m_pc, 32'h0000_001C);
    jr_to(32'h0000_0020);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, '0, 1'b0);

    // Jump beats branch; jr beats jump.
    jr_to(32'h3000_0040);
    run_instr(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, '0, 1'b0);
    check_eq("jump_pc", m_pc, 32'h3000_0400);
    run_instr(32'h0000_0008, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h0000_1237, 1'b0);
    check_eq("jr_pc", m_pc, 32'h0000_1234);

    // Wraparound at top of address space.
    jr_to(32'hFFFF_FFFC);
    run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check_eq("wrap_pc", bus.pc, 32'h0000_0000);

    // Reset mid-fetch at 0x40 with ack landing in the reset cycle.
    jr_to(32'h0000_0040);
    step();
    check_eq("mid_req", {31'b0, bus.imem_req}, 32'd1);
    check_eq("mid_addr", bus.imem_addr, 32'h0000_0040);
    rst = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    check_eq("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    step();
    check_eq("mid_after_valid", {31'b0, bus.instr_valid}, 32'd0);
    check_eq("mid_after_instr", bus.instr, 32'd0);
    m_pc = RST_PC;
    run_instr(32'h2008_0005, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Randomized traffic with spurious exec_done/imem_ack outside their states.
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic br, z, j, r;
      sel = $urandom_range(0, 7);
      br = (sel == 1) || (sel == 2);
      z  = 1'($urandom_range(0, 1));
      j  = (sel == 3);
      r  = (sel == 4) || (sel == 5 && 1'($urandom_range(0, 1)));
      if (sel == 5) j = 1'b1;
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                br, z, j, r, $urandom, $urandom, 1'b1);
    end

    step();
    check_eq("valid_pulses", n_valid_seen, n_issued);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
